// File: rtl/ring_pkg.sv
// rtl/ring_pkg.sv - shared ring router packet layout and link constants
package ring_pkg;

    localparam int PACKET_SIZE = 49;

    localparam int VALID_BIT = 48;
    localparam int TS_MSB    = 47;
    localparam int TS_LSB    = 32;
    localparam int SRC_MSB   = 31;
    localparam int SRC_LSB   = 16;
    localparam int DST_MSB   = 15;
    localparam int DST_LSB   = 0;

    // Downstream on/off flow control: 1 means the link is switched off
    localparam logic BP_OFF = 1'b1;

endpackage

// File: rtl/ring_stat_counter.sv
// rtl/ring_stat_counter.sv - wrapping statistics counter with increment strobe
module ring_stat_counter #(
    parameter int CNT_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count
);

    // Count increment strobes; wraps naturally modulo 2^CNT_WIDTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/ring_link_arbiter.sv
// rtl/ring_link_arbiter.sv - through/injection arbiter driving one ring output link
module ring_link_arbiter #(
    parameter int PACKET_SIZE    = ring_pkg::PACKET_SIZE,
    parameter int MAX_THRU_BURST = 4,
    parameter int CNT_WIDTH      = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   thru_valid,
    input  logic [PACKET_SIZE-1:0] thru_pkt,
    output logic                   thru_ready,
    input  logic                   inj_valid,
    input  logic [PACKET_SIZE-1:0] inj_pkt,
    output logic                   inj_ready,
    input  logic                   backpressure_rd,
    output logic [PACKET_SIZE-1:0] link_out,
    output logic [CNT_WIDTH-1:0]   total_packet_sent,
    output logic [CNT_WIDTH-1:0]   total_forwarded
);
    import ring_pkg::*;

    localparam logic [3:0] BURST_LIMIT = 4'(MAX_THRU_BURST);

    logic [3:0] burst_cnt;
    logic       link_on;
    logic       thru_win;
    logic       thru_xfer;
    logic       inj_xfer;

    // Grant: through has priority until it has used its burst allowance
    // while injection waits; readies are forced low in reset or when off
    always_comb begin
        link_on    = rst_n && (backpressure_rd != BP_OFF);
        thru_win   = thru_valid && (!inj_valid || (burst_cnt != BURST_LIMIT));
        thru_xfer  = link_on && thru_win;
        inj_xfer   = link_on && inj_valid && !thru_win;
        thru_ready = thru_xfer;
        inj_ready  = inj_xfer;
    end

    // Track consecutive through grants taken while injection is waiting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_cnt <= '0;
        end else if (!inj_valid || inj_xfer) begin
            burst_cnt <= '0;
        end else if (thru_xfer) begin
            burst_cnt <= burst_cnt + 1'b1;
        end
    end

    // Register the granted packet with VALID forced on, idle word otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            link_out <= '0;
        end else if (thru_xfer) begin
            link_out <= {1'b1, thru_pkt[PACKET_SIZE-2:0]};
        end else if (inj_xfer) begin
            link_out <= {1'b1, inj_pkt[PACKET_SIZE-2:0]};
        end else begin
            link_out <= '0;
        end
    end

    ring_stat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_sent_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (inj_xfer),
        .count (total_packet_sent)
    );

    ring_stat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_fwd_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (thru_xfer),
        .count (total_forwarded)
    );

endmodule

// File: tb/tb_ring_link_arbiter.sv
// tb/tb_ring_link_arbiter.sv - directed self-checking bench for ring_link_arbiter
module tb_ring_link_arbiter;

    logic        clk;
    logic        rst_n;
    logic        thru_valid;
    logic [48:0] thru_pkt;
    logic        thru_ready;
    logic        inj_valid;
    logic [48:0] inj_pkt;
    logic        inj_ready;
    logic        backpressure_rd;
    logic [48:0] link_out;
    logic [63:0] total_packet_sent;
    logic [63:0] total_forwarded;

    logic        w_inj_valid;
    logic [48:0] w_inj_pkt;
    logic        w_thru_ready;
    logic        w_inj_ready;
    logic [48:0] w_link_out;
    logic [3:0]  w_sent;
    logic [3:0]  w_fwd;

    int checks;
    int errors;

    ring_link_arbiter #(.PACKET_SIZE(49), .MAX_THRU_BURST(4), .CNT_WIDTH(64)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .thru_valid        (thru_valid),
        .thru_pkt          (thru_pkt),
        .thru_ready        (thru_ready),
        .inj_valid         (inj_valid),
        .inj_pkt           (inj_pkt),
        .inj_ready         (inj_ready),
        .backpressure_rd   (backpressure_rd),
        .link_out          (link_out),
        .total_packet_sent (total_packet_sent),
        .total_forwarded   (total_forwarded)
    );

    ring_link_arbiter #(.PACKET_SIZE(49), .MAX_THRU_BURST(4), .CNT_WIDTH(4)) dut_w (
        .clk               (clk),
        .rst_n             (rst_n),
        .thru_valid        (1'b0),
        .thru_pkt          (49'h0),
        .thru_ready        (w_thru_ready),
        .inj_valid         (w_inj_valid),
        .inj_pkt           (w_inj_pkt),
        .inj_ready         (w_inj_ready),
        .backpressure_rd   (1'b0),
        .link_out          (w_link_out),
        .total_packet_sent (w_sent),
        .total_forwarded   (w_fwd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Entered at posedge+1: drive, check readies, clock, check the link word
    task automatic do_cycle(input string tag, input logic tv, input logic [48:0] tp,
                            input logic iv, input logic [48:0] ip, input logic bp,
                            input logic exp_t, input logic exp_i);
        logic [48:0] exp_link;
        thru_valid      = tv;
        thru_pkt        = tp;
        inj_valid       = iv;
        inj_pkt         = ip;
        backpressure_rd = bp;
        #1;
        check_val({tag, " thru_ready"}, 64'(thru_ready), 64'(exp_t));
        check_val({tag, " inj_ready"}, 64'(inj_ready), 64'(exp_i));
        if (exp_t)      exp_link = {1'b1, tp[47:0]};
        else if (exp_i) exp_link = {1'b1, ip[47:0]};
        else            exp_link = 49'h0;
        @(posedge clk);
        #1;
        check_val({tag, " link_out"}, 64'(link_out), 64'(exp_link));
    endtask

    task automatic apply_reset();
        thru_valid      = 1'b0;
        inj_valid       = 1'b0;
        backpressure_rd = 1'b0;
        w_inj_valid     = 1'b0;
        rst_n           = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    logic [48:0] tp;
    logic [48:0] ip;
    // Expected grant pattern for both-valid runs: 1 = through, 0 = injection
    logic [9:0]  seq10;

    initial begin
        checks          = 0;
        errors          = 0;
        rst_n           = 1'b1;
        thru_valid      = 1'b0;
        thru_pkt        = '0;
        inj_valid       = 1'b0;
        inj_pkt         = '0;
        backpressure_rd = 1'b0;
        w_inj_valid     = 1'b0;
        w_inj_pkt       = '0;
        #2;

        // Reset state with requests pending: readies must stay low
        rst_n      = 1'b0;
        thru_valid = 1'b1;
        inj_valid  = 1'b1;
        #2;
        check_val("rst link_out", 64'(link_out), 64'h0);
        check_val("rst sent", total_packet_sent, 64'h0);
        check_val("rst fwd", total_forwarded, 64'h0);
        check_val("rst thru_ready", 64'(thru_ready), 64'h0);
        check_val("rst inj_ready", 64'(inj_ready), 64'h0);
        apply_reset();

        // Injection only
        do_cycle("inj1", 1'b0, 49'h0, 1'b1, 49'h0_0001_0002_0003, 1'b0, 1'b0, 1'b1);
        check_val("inj1 value", 64'(link_out), 64'h1_0001_0002_0003);
        check_val("inj1 sent", total_packet_sent, 64'd1);
        do_cycle("inj1 idle", 1'b0, 49'h0, 1'b0, 49'h0, 1'b0, 1'b0, 1'b0);

        // Both valid for 10 cycles: T,T,T,T,I,T,T,T,T,I (input MSB set, ignored)
        apply_reset();
        seq10 = 10'b1111011110;
        for (int i = 0; i < 10; i++) begin
            tp = {1'b1, 16'hA000 + 16'(i), 16'h1111, 16'h2222};
            ip = {1'b0, 16'hB000 + 16'(i), 16'h3333, 16'h4444};
            do_cycle($sformatf("burst c%0d", i), 1'b1, tp, 1'b1, ip, 1'b0,
                     seq10[9-i], !seq10[9-i]);
        end
        check_val("burst fwd", total_forwarded, 64'd8);
        check_val("burst sent", total_packet_sent, 64'd2);

        // Backpressure holds burst_cnt: T,T, 3 off cycles, then T,T,I
        apply_reset();
        ip = 49'h0_00CC_00DD_00EE;
        do_cycle("bp t0", 1'b1, 49'h0_0E01_0001_0001, 1'b1, ip, 1'b0, 1'b1, 1'b0);
        do_cycle("bp t1", 1'b1, 49'h0_0E02_0001_0001, 1'b1, ip, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++)
            do_cycle($sformatf("bp off%0d", i), 1'b1, 49'h0_0E03_0001_0001, 1'b1, ip,
                     1'b1, 1'b0, 1'b0);
        do_cycle("bp t2", 1'b1, 49'h0_0E04_0001_0001, 1'b1, ip, 1'b0, 1'b1, 1'b0);
        do_cycle("bp t3", 1'b1, 49'h0_0E05_0001_0001, 1'b1, ip, 1'b0, 1'b1, 1'b0);
        do_cycle("bp i", 1'b1, 49'h0_0E06_0001_0001, 1'b1, ip, 1'b0, 1'b0, 1'b1);
        check_val("bp fwd", total_forwarded, 64'd4);

        // Single-cycle injection pulse during through stream, then both valid
        apply_reset();
        ip = 49'h0_0D00_0D00_0D00;
        for (int i = 1; i <= 6; i++)
            do_cycle($sformatf("pulse c%0d", i), 1'b1, {1'b0, 16'h0C00 + 16'(i), 32'h5},
                     (i == 3), ip, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++)
            do_cycle($sformatf("pulse both%0d", i), 1'b1, {1'b0, 16'h0F00 + 16'(i), 32'h6},
                     1'b1, ip, 1'b0, (i < 4), (i == 4));
        check_val("pulse sent", total_packet_sent, 64'd1);

        // Asynchronous reset after 5 transfers, mid-cycle
        apply_reset();
        for (int i = 0; i < 5; i++)
            do_cycle($sformatf("mid c%0d", i), 1'b0, 49'h0, 1'b1,
                     {1'b0, 16'h7000 + 16'(i), 32'h7}, 1'b0, 1'b0, 1'b1);
        check_val("mid sent pre", total_packet_sent, 64'd5);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("mid link_out", 64'(link_out), 64'h0);
        check_val("mid sent", total_packet_sent, 64'h0);
        check_val("mid fwd", total_forwarded, 64'h0);
        check_val("mid inj_ready", 64'(inj_ready), 64'h0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        inj_valid = 1'b0;
        do_cycle("mid after", 1'b1, 49'h0_0123_4567_89AB, 1'b0, 49'h0, 1'b0, 1'b1, 1'b0);
        check_val("mid after fwd", total_forwarded, 64'd1);
        check_val("mid after sent", total_packet_sent, 64'd0);

        // 4-bit counter build wraps after 16 injections
        apply_reset();
        w_inj_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            w_inj_pkt = {1'b0, 16'(i), 32'h9};
            #1;
            check_val($sformatf("wrap ready%0d", i), 64'(w_inj_ready), 64'h1);
            @(posedge clk);
            #1;
            if (i == 14) check_val("wrap sent 15", 64'(w_sent), 64'd15);
        end
        check_val("wrap sent 16", 64'(w_sent), 64'd0);
        check_val("wrap link", 64'(w_link_out), 64'h1_000F_0000_0009);
        w_inj_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ring_link_arbiter.md
# ring_link_arbiter

Output-link arbiter for one direction (east or west) of a ring router. Two requesters share the outgoing link register: through traffic from the opposite input buffer and local injection from the node's traffic generator. The arbiter honours the downstream on/off backpressure and registers the winning packet onto the link. It also keeps per-requester transfer counters for the node statistics. One instance drives each output direction of every ring node.

## Interface
- PACKET_SIZE, 49: packet width. Bit 48 is VALID, [47:32] timestamp, [31:16] source, [15:0] destination.
- MAX_THRU_BURST, 4: maximum consecutive through grants while injection waits. Legal range is 1..15.
- CNT_WIDTH, 64: width of the statistics counters.
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- thru_valid  in  1  through packet available
- thru_pkt  in  PACKET_SIZE  through packet
- thru_ready  out  1  through packet accepted this cycle (combinational)
- inj_valid  in  1  local packet available
- inj_pkt  in  PACKET_SIZE  local packet
- inj_ready  out  1  local packet accepted this cycle (combinational)
- backpressure_rd  in  1  downstream on/off state; 1 = off (stop), 0 = on
- link_out  out  PACKET_SIZE  registered link word; MSB is the VALID bit
- total_packet_sent  out  CNT_WIDTH  count of injected packets placed on the link
- total_forwarded  out  CNT_WIDTH  count of through packets placed on the link

## Operation
- A transfer occurs when valid & ready. At most one ready is high per cycle.
- Both readies are 0 while backpressure_rd=1 or rst_n=0.
- Grant rule when backpressure_rd=0:
  - Only one requester valid: that requester wins.
  - Both valid: through wins, unless burst_cnt == MAX_THRU_BURST, in which case injection wins.
- burst_cnt is a 4-bit register.
  - +1 on a through transfer while inj_valid=1.
  - Cleared to 0 on an injection transfer, and on any cycle with inj_valid=0.
  - Holds its value while backpressure_rd=1 and inj_valid=1.
- Link word:
  - On a transfer, link_out <= granted packet with the MSB forced to 1. The pkt MSB on the inputs is ignored.
  - With no transfer, link_out <= all zeros (idle word, VALID=0).
- Counters:
  - total_packet_sent +1 per injection transfer.
  - total_forwarded +1 per through transfer.
  - Both are unsigned and wrap modulo 2^CNT_WIDTH.
- Packets are never dropped, duplicated or modified apart from the VALID bit. The field contents (timestamp/src/dst) pass through bit-exact.

## Timing
- Reset values (asynchronous, immediate on rst_n falling):
  - link_out = 0
  - burst_cnt = 0
  - total_packet_sent = 0
  - total_forwarded = 0
  - thru_ready = inj_ready = 0
- Latency: a packet accepted in cycle N appears on link_out in cycle N+1 and remains for exactly one cycle.
- Throughput: one packet per cycle while backpressure_rd=0.
- Backpressure:
  - Sampled combinationally in the same cycle. backpressure_rd=1 in cycle N means no transfer in N, so link_out is idle in N+1.
  - The downstream buffer absorbs the one in-flight word with its off-threshold margin.
- Starvation bound: with both requesters continuously valid and the link on, injection receives exactly 1 of every MAX_THRU_BURST+1 grants.
- Reset mid-operation: the word in link_out is lost (cleared), and counters restart from 0. After rst_n rises, the first transfer is possible in the first clock edge with rst_n=1.

## Structure
- Shared package ring_pkg holds:
  - PACKET_SIZE.
  - Field offsets VALID_BIT=48, TS_MSB/LSB=47/32, SRC_MSB/LSB=31/16, DST_MSB/LSB=15/0.
  - The on/off encoding constant BP_OFF=1'b1.
- Sub-module ring_stat_counter (CNT_WIDTH parameter; inputs clk, rst_n, inc; output count) is instantiated twice for the statistics counters.
- Grant logic and burst_cnt live in ring_link_arbiter itself.

## Test plan
- Only inj_valid=1 with inj_pkt=49'h0_0001_0002_0003 and backpressure 0 -> inj_ready=1. link_out=49'h1_0001_0002_0003 next cycle, and total_packet_sent=1.
- Both valid continuously for 10 cycles, MAX_THRU_BURST=4, link on -> grant sequence T,T,T,T,I,T,T,T,T,I. total_forwarded=8 and total_packet_sent=2.
- Both valid with backpressure_rd=1 for 3 cycles, then 0 -> both readies 0 and link_out=0 for those 3 cycles. burst_cnt is unchanged, and transfers resume in the cycle after backpressure drops.
- thru_valid=1 for 6 cycles with inj_valid pulsing high only in cycle 3 -> through wins in cycle 3 and burst_cnt clears in cycle 4. Injection is granted no earlier than after 4 further through grants.
- rst_n asserted mid-stream after 5 transfers -> link_out, both counters and both readies go to 0 immediately. After release, the first transfer yields a counter value of 1.
- Counters preset near wrap (CNT_WIDTH=4 build, 15 injection transfers plus 1 more) -> total_packet_sent reads 0 after the 16th.
